// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default word width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous UART input; resets to the idle-high level.
module uart_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start-bit validation, mid-bit sampling, stop-bit check,
// and a single-entry valid/ready output register with overrun and framing-error pulses.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sdata_rx_in,
  output logic [DATA_WIDTH-1:0] data_rx_out,
  output logic                  valid_rx_out,
  input  logic                  ready_rx_in,
  output logic                  frame_err_out,
  output logic                  overrun_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  logic                  line;
  uart_rx_state_t        state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  ferr_reg, ferr_next;
  logic                  ovr_reg, ovr_next;
  logic                  deliver;

  uart_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (sdata_rx_in),
    .sync_out (line)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    ferr_next  = 1'b0;
    deliver    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!line) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          // A start bit that has gone high again by mid-bit is noise.
          state_next = line ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {line, shift_reg[DATA_WIDTH-1:1]};
          idx_next   = idx_reg + IW'(1);
          if (idx_reg == IDX_LAST) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (line) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      BREAK: begin
        if (line) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output slot: a consume and a delivery in the same cycle hand over directly.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    ovr_next   = 1'b0;

    if (valid_reg && ready_rx_in) valid_next = 1'b0;

    if (deliver) begin
      if (!valid_reg || ready_rx_in) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end
  end

  assign data_rx_out   = data_reg;
  assign valid_rx_out  = valid_reg;
  assign frame_err_out = ferr_reg;
  assign overrun_out   = ovr_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized and directed bench for uart_rx_deser against a word-level model of the
// receiver (expected word queue, one-entry output slot, expected error-pulse counts).
module tb_uart_rx_deser;

  localparam int BIT_CLKS = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sdata_rx_in = 1'b1;
  logic [7:0] data_rx_out;
  logic       valid_rx_out;
  logic       ready_rx_in = 1'b1;
  logic       frame_err_out;
  logic       overrun_out;

  int n_vec  = 0;
  int n_miss = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = -1;
  int valid_hi = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;
  logic prev_valid = 1'b0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       slot_full = 1'b0;
  logic [7:0] slot_word = 8'h00;
  int         exp_ferr = 0;
  int         exp_ovr = 0;

  uart_rx_deser #(.CLKS_PER_BIT(BIT_CLKS), .DATA_WIDTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .sdata_rx_in   (sdata_rx_in),
    .data_rx_out   (data_rx_out),
    .valid_rx_out  (valid_rx_out),
    .ready_rx_in   (ready_rx_in),
    .frame_err_out (frame_err_out),
    .overrun_out   (overrun_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Output monitor: sampled at negedge, where outputs are settled for the coming edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_rx_out && ready_rx_in) begin
        if (exp_q.size() == 0) check("spurious_word", 32'(data_rx_out), 32'hffff_ffff);
        else check("word", 32'(data_rx_out), 32'(exp_q.pop_front()));
      end
      if (valid_rx_out && !prev_valid) rise_cyc = cyc;
      if (valid_rx_out) valid_hi++;
      if (frame_err_out) ferr_seen++;
      if (overrun_out) ovr_seen++;
      prev_valid = valid_rx_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  // Model: a good frame goes to the consumer, into the slot, or is dropped as overrun.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) exp_ferr++;
    else if (slot_full) exp_ovr++;
    else if (ready_rx_in) exp_q.push_back(d);
    else begin
      slot_full = 1'b1;
      slot_word = d;
    end
  endtask

  task automatic set_ready(input logic r);
    if (r && slot_full) begin
      exp_q.push_back(slot_word);
      slot_full = 1'b0;
    end
    ready_rx_in = r;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    sdata_rx_in = 1'b0;
    fall_cyc = cyc;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      sdata_rx_in = d[i];
      tick(BIT_CLKS);
    end
    sdata_rx_in = stop;
    model_frame(d, stop);
    tick(BIT_CLKS);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
    check({tag, "_ovr"}, 32'(ovr_seen), 32'(exp_ovr));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [7:0] d;
    logic       stop;

    // Reset state
    tick(3);
    check("rst_data", 32'(data_rx_out), 32'd0);
    check("rst_valid", 32'(valid_rx_out), 32'd0);
    check("rst_ferr", 32'(frame_err_out), 32'd0);
    check("rst_ovr", 32'(overrun_out), 32'd0);
    reset = 1'b0;
    tick(20);

    // 1: single frame, latency and one-cycle valid with ready held high
    v0 = valid_hi;
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    tick(5);
    check("s1_latency_ok", 32'((rise_cyc - fall_cyc) >= 154 && (rise_cyc - fall_cyc) <= 156), 32'd1);
    check("s1_valid_width", 32'(valid_hi - v0), 32'd1);
    check_counts("s1");

    // 2: short low glitch is rejected, following frame received
    sdata_rx_in = 1'b0;
    tick(4);
    sdata_rx_in = 1'b1;
    tick(30);
    check("s2_no_valid", 32'(valid_hi - v0), 32'd1);
    send_frame(8'h3C, 1'b1);
    tick(5);
    check_counts("s2");

    // 3: framing error followed by a held-low break, then recovery
    send_frame(8'h3C, 1'b0);
    tick(40);
    sdata_rx_in = 1'b1;
    tick(BIT_CLKS);
    send_frame(8'h5A, 1'b1);
    tick(5);
    check_counts("s3");

    // 4: consumer stalled, second word overruns, then consumed
    set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    check("s4_hold_data", 32'(data_rx_out), 32'h11);
    check("s4_hold_valid", 32'(valid_rx_out), 32'd1);
    check_counts("s4_stalled");
    set_ready(1'b1);
    tick(1);
    check("s4_valid_drop", 32'(valid_rx_out), 32'd0);
    check_counts("s4");

    // 5: reset in the middle of the data bits with a word pending
    set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    tick(5);
    check("s5_pending", 32'(valid_rx_out), 32'd1);
    sdata_rx_in = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      sdata_rx_in = 1'($urandom_range(0, 1));
      tick(BIT_CLKS);
    end
    reset = 1'b1;
    #1;
    check("s5_rst_data", 32'(data_rx_out), 32'd0);
    check("s5_rst_valid", 32'(valid_rx_out), 32'd0);
    check("s5_rst_pulses", 32'({frame_err_out, overrun_out}), 32'd0);
    slot_full = 1'b0;
    sdata_rx_in = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    set_ready(1'b1);
    send_frame(8'hFF, 1'b1);
    tick(5);
    check_counts("s5");

    // 6: back-to-back frames with single stop bits
    send_frame(8'h00, 1'b1);
    send_frame(8'h80, 1'b1);
    tick(5);
    check_counts("s6");

    // Randomized frames: random data, gaps, and occasional bad stop bits
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      if (!stop) begin
        tick($urandom_range(5, 30));
        sdata_rx_in = 1'b1;
        tick(BIT_CLKS);
      end else begin
        tick($urandom_range(0, 3));
      end
    end
    tick(10);
    check_counts("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
Receive-side deserializer of the UART. It takes the asynchronous serial line, detects and validates start bits, and samples DATA_WIDTH data bits LSB-first. It checks the stop bit and presents each good word on a parallel valid/ready output port. It is the counterpart of the TX serializer and feeds the parallel RX side of the UART top.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 4; even values preferred.
DATA_WIDTH, 8, data bits per frame; no parity; one stop bit.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
sdata_rx_in  input  1  serial line; idle high; asynchronous to clock.
data_rx_out  output  DATA_WIDTH  received word; stable while valid_rx_out=1.
valid_rx_out  output  1  word available.
ready_rx_in  input  1  consumer accepts the word when valid_rx_out && ready_rx_in at posedge.
frame_err_out  output  1  one-cycle pulse when the stop bit is sampled 0.
overrun_out  output  1  one-cycle pulse when a completed word is dropped because the output is occupied.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is asynchronous and active-high.
- Reset values: data_rx_out=0, valid_rx_out=0, frame_err_out=0, overrun_out=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: sdata_rx_in passes through a 2-flop synchronizer. "line" below means the synchronizer output, which lags the pin by 2 cycles.
- Bit counter: width $clog2(CLKS_PER_BIT).
- Data-bit index: width $clog2(DATA_WIDTH+1).
- Shift register: new bit enters at the MSB and shifts right, so the first received bit ends up in bit 0.
- IDLE: when line=0, go to START and clear the counter.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample the line at mid-bit.
  - line=0: go to DATA, clear counter and bit index.
  - line=1: treat as a glitch and return to IDLE with no outputs.
- DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register.
  - After DATA_WIDTH samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample the line.
  - line=1: deliver the word and go to IDLE. The IDLE state can accept a new start edge on the very next cycle, so back-to-back frames with a single stop bit are supported.
  - line=0: pulse frame_err_out, discard the word, go to BREAK.
- BREAK: stay until line=1, then go to IDLE. No start detection happens while in BREAK.
- Delivery: word delivery takes effect at the clock edge following the stop-bit sample, as follows.
  - valid_rx_out=0: load data_rx_out and set valid_rx_out.
  - valid_rx_out=1 and ready_rx_in=1 in the same cycle: the old word is consumed, the new word is loaded, valid_rx_out stays 1, no overrun.
  - valid_rx_out=1 and ready_rx_in=0: keep the old word, drop the new one, pulse overrun_out.
- Handshake:
  - valid_rx_out clears on a valid && ready cycle when no delivery happens that cycle.
  - data_rx_out does not change while valid_rx_out=1 unless it is consumed.
  - ready_rx_in is ignored while valid_rx_out=0.
- Latency: valid_rx_out rises 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles after the pin falling edge (±1 cycle of synchronizer phase).
- Reset mid-frame: all state is cleared immediately (asynchronously). A pending word is lost and no error pulses are generated. The block resumes in IDLE.
- Pulses: frame_err_out and overrun_out are each high for exactly one cycle per event. They are registered outputs.

Decomposition:
- Package uart_pkg:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - constant UART_DATA_WIDTH=8, used as the default for DATA_WIDTH.
- Sub-module uart_sync: 2-flop synchronizer with reset value 1. It is reused by any other asynchronous UART input.

Test Plan:
(All scenarios use CLKS_PER_BIT=16 and DATA_WIDTH=8; pin bit period is 16 clocks.)
1. Frame 0xA5 with ready_rx_in held 1 -> valid_rx_out high exactly 1 cycle, data_rx_out=0xA5, no error pulses; latency within ±1 of 2+8+144+1=155 cycles.
2. Pin low for 4 clocks, then high -> no valid_rx_out, no frame_err_out; a following frame 0x3C is received as 0x3C.
3. Frame 0x3C with the stop bit forced 0 and the line held low for 40 more clocks -> one frame_err_out pulse, no valid; next frame 0x5A after the line returns high -> data_rx_out=0x5A.
4. ready_rx_in=0, frames 0x11 then 0x22 -> data_rx_out stays 0x11, one overrun_out pulse at the end of frame 2; then ready_rx_in=1 -> 0x11 consumed, valid_rx_out drops next cycle.
5. reset pulsed during DATA after 3 bits -> all outputs 0 within the same cycle; next full frame 0xFF -> data_rx_out=0xFF.
6. Back-to-back frames 0x00 then 0x80 with single stop bits, ready_rx_in=1 -> two valid pulses in order, 0x00 then 0x80, no errors.
